bitmap_field_unpacker: RTL and testbench
========================================

Name: bitmap_field_unpacker

Overview:
Downstream consumer of the bitmap translation stage. It parses a compressed block from a 32-bit input stream: one header word carrying a 16-bit bitmap, then a packed payload. It computes the cumulative field end offsets internally, using the same 2-bit width code, and buffers the payload. It then emits the 8 decoded fields in parallel over a valid/ready handshake.

Parameters:
OUT_W, 32, width of each output field; must be >= 32; fields are zero-extended into it.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
in_data  input  32  stream word (header or payload)
in_valid  input  1  in_data valid
in_ready  output  1  block accepts in_data this cycle
out_valid  output  1  decoded field set available
out_ready  input  1  downstream accepts field set
out_bitmap  output  16  bitmap of the block being emitted
out_total  output  9  total payload bits, 0..256
out_val_0 .. out_val_7  output  OUT_W each  decoded fields 0..7

Behaviour:
- Reset and clocking: one clock, clk. rst is asynchronous, active-high.
- Reset state: FSM=HDR, in_ready=1, out_valid=0, out_bitmap=0, out_total=0, payload buffer=0, word counter=0, all out_val_*=0.
- Width code: 2-bit code per field i at bitmap[2i+1:2i]. 00->0, 01->8, 10->16, 11->32 bits.
- Offsets: end_i = sum of width_0..width_i. start_i = end_(i-1), with start_0 = 0. total = end_7, range 0..256. Sums use 9-bit arithmetic with no overflow possible.
- Payload packing: bits are LSB-first across words. Payload word k fills buffer bits [32k+31:32k]. Field i = buffer[start_i +: width_i], zero-extended to OUT_W. A width-0 field gives 0.
- Payload word count: nwords = (total+31)>>5, range 0..8. Bits beyond total in the last word are ignored.
- FSM states: HDR, LOAD, EMIT.
- HDR:
  - in_ready=1.
  - On in_valid: latch bitmap = in_data[15:0]; in_data[31:16] is ignored.
  - Compute and latch total and nwords; clear the buffer and the word counter.
  - If nwords==0, go to EMIT; otherwise go to LOAD.
- LOAD:
  - in_ready=1.
  - Each in_valid cycle writes in_data to buffer word[counter] and increments the counter.
  - The handshake that delivers word nwords-1 moves the FSM to EMIT.
  - in_valid low: hold state; no timeout.
- EMIT:
  - in_ready=0 and out_valid=1.
  - out_val_*, out_bitmap and out_total are driven from registered state. They are stable throughout EMIT.
  - On out_ready: go to HDR next cycle, with out_valid=0.
  - out_ready held low: hold indefinitely with outputs unchanged.
- Latency: out_valid rises the cycle after the last payload handshake. For a zero-length block, it rises the cycle after the header handshake.
- Throughput: no header is accepted in the EMIT cycle. The minimum block period is nwords+2 cycles.
- Outside EMIT: out_val_* may change, but they are only meaningful while out_valid=1.
- Reset mid-operation: an immediate return to the reset state. A partial block is discarded; no output is produced for it.

Optional Feature:
Macro UNPACK_SIGN_EXT_EN.
- Defined: each nonzero-width field is sign-extended from its top bit (bit width_i-1) to OUT_W. Width-0 fields remain 0.
- Undefined: zero extension only, and no sign-extension logic is synthesised.

Test Plan:
1. Reset, then header 0x0000_0000 -> no payload consumed. out_valid=1 one cycle later, with out_total=0 and all out_val_*=0. out_ready=1 returns the FSM to HDR.
2. Header 0x0000_5555, payload 0x44332211, 0x88776655 -> out_total=64. out_val_0..7 = 0x11, 0x22, 0x33, 0x44, 0x55, 0x66, 0x77, 0x88.
3. Header 0x0000_0006, payload 0xDDCCBBAA -> out_total=24, out_val_0=0xBBAA, out_val_1=0xCC, others 0. Byte 0xDD is ignored.
4. Header 0xABCD_FFFF, payload 8 words 0x0..0x7 -> out_bitmap=0xFFFF, out_total=256, out_val_i=i. Header bits [31:16] are ignored.
5. Bitmap 0x5555 with out_ready held low 10 cycles -> out_valid and out_val_* stable, in_ready=0 throughout. A new header offered meanwhile is accepted only after the out_ready handshake.
6. Assert rst after 1 of 2 payload words -> FSM=HDR, out_valid=0. A following 0x0000 block emits all zeros.
   - With UNPACK_SIGN_EXT_EN, bitmap 0x0001 and payload 0x00000080 -> out_val_0=0xFFFFFF80.

Source files
------------

// File: rtl/bitmap_field_unpacker.sv
// bitmap_field_unpacker
//   Parses one compressed block from a 32-bit stream. The first word is a header
//   whose low 16 bits form a bitmap of eight 2-bit width codes (00=0, 01=8,
//   10=16, 11=32 bits). It is followed by (total+31)>>5 payload words, packed
//   LSB-first. When the block is complete, the eight fields are presented in
//   parallel over a valid/ready handshake.
//
//   Optional build macro: UNPACK_SIGN_EXT_EN
//     defined   -> each nonzero-width field is sign-extended to OUT_W
//     undefined -> fields are zero-extended to OUT_W
//
//   Ports:
//     clk, rst              clock (rising edge); asynchronous active-high reset
//     in_data, in_valid     header or payload word, and its qualifier
//     in_ready              high in HDR and LOAD
//     out_valid, out_ready  handshake for the decoded field set
//     out_bitmap            bitmap of the block being emitted
//     out_total             total payload bits, 0..256
//     out_val_0..7          decoded fields, OUT_W bits each
module bitmap_field_unpacker #(
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_bitmap,
   output logic [8:0]       out_total,
   output logic [OUT_W-1:0] out_val_0,
   output logic [OUT_W-1:0] out_val_1,
   output logic [OUT_W-1:0] out_val_2,
   output logic [OUT_W-1:0] out_val_3,
   output logic [OUT_W-1:0] out_val_4,
   output logic [OUT_W-1:0] out_val_5,
   output logic [OUT_W-1:0] out_val_6,
   output logic [OUT_W-1:0] out_val_7
);

   typedef enum logic [1:0] {HDR, LOAD, EMIT} state_t;

   state_t        state_r, state_nx;
   logic [15:0]   bitmap_r;
   logic [8:0]    total_r;
   logic [3:0]    nwords_r;
   logic [3:0]    cnt_r;
   logic [255:0]  buf_r;
   logic [8:0]    hdr_total;
   logic [3:0]    hdr_nwords;
   logic [OUT_W-1:0] fields [8];

   function automatic logic [8:0] code_width(input logic [1:0] code);
      case (code)
         2'b00:   code_width = 9'd0;
         2'b01:   code_width = 9'd8;
         2'b10:   code_width = 9'd16;
         default: code_width = 9'd32;
      endcase
   endfunction

   function automatic logic [8:0] bitmap_total(input logic [15:0] bm);
      logic [8:0] sum;
      sum = '0;
      for (int i = 0; i < 8; i++) sum = sum + code_width(bm[2*i +: 2]);
      return sum;
   endfunction

   // Pull one field out of the payload buffer and extend it to OUT_W.
   function automatic logic [OUT_W-1:0] extract_field(input logic [255:0] b,
                                                      input logic [8:0]   start,
                                                      input logic [1:0]   code);
      logic [31:0] raw;
      logic [OUT_W-1:0] r;
      raw = 32'(b >> start);
      r   = '0;
      case (code)
`ifdef UNPACK_SIGN_EXT_EN
         2'b01:   r = OUT_W'($signed(raw[7:0]));
         2'b10:   r = OUT_W'($signed(raw[15:0]));
         2'b11:   r = OUT_W'($signed(raw));
`else
         2'b01:   r = OUT_W'(raw[7:0]);
         2'b10:   r = OUT_W'(raw[15:0]);
         2'b11:   r = OUT_W'(raw);
`endif
         default: r = '0;
      endcase
      return r;
   endfunction

   // Header decode happens in the accept cycle, so LOAD knows its word count.
   assign hdr_total  = bitmap_total(in_data[15:0]);
   assign hdr_nwords = 4'(({1'b0, hdr_total} + 10'd31) >> 5);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= HDR;
      else     state_r <= state_nx;
   end

   always_comb begin
      state_nx  = state_r;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_r)
         HDR: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = (hdr_nwords == 4'd0) ? EMIT : LOAD;
         end
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid && (cnt_r + 4'd1 == nwords_r)) state_nx = EMIT;
         end
         EMIT: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = HDR;
         end
         default: state_nx = HDR;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bitmap_r <= '0;
         total_r  <= '0;
         nwords_r <= '0;
         cnt_r    <= '0;
         buf_r    <= '0;
      end else if (in_valid && state_r == HDR) begin
         bitmap_r <= in_data[15:0];
         total_r  <= hdr_total;
         nwords_r <= hdr_nwords;
         cnt_r    <= '0;
         buf_r    <= '0;
      end else if (in_valid && state_r == LOAD) begin
         buf_r[{cnt_r[2:0], 5'd0} +: 32] <= in_data;
         cnt_r                          <= cnt_r + 4'd1;
      end
   end

   // Field extraction works from the registered bitmap and buffer, which
   // are frozen throughout EMIT, so the outputs hold steady there.
   always_comb begin
      logic [8:0] start;
      start = '0;
      for (int i = 0; i < 8; i++) begin
         fields[i] = extract_field(buf_r, start, bitmap_r[2*i +: 2]);
         start     = start + code_width(bitmap_r[2*i +: 2]);
      end
   end

   assign out_bitmap = bitmap_r;
   assign out_total  = total_r;
   assign out_val_0  = fields[0];
   assign out_val_1  = fields[1];
   assign out_val_2  = fields[2];
   assign out_val_3  = fields[3];
   assign out_val_4  = fields[4];
   assign out_val_5  = fields[5];
   assign out_val_6  = fields[6];
   assign out_val_7  = fields[7];

endmodule

// File: tb/tb_bitmap_field_unpacker.sv
module tb_bitmap_field_unpacker;
   localparam int OUT_W = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [31:0]      in_data;
   logic             in_valid;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_bitmap;
   logic [8:0]       out_total;
   logic [OUT_W-1:0] ov [8];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bitmap_field_unpacker #(.OUT_W(OUT_W)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_bitmap(out_bitmap), .out_total(out_total),
      .out_val_0(ov[0]), .out_val_1(ov[1]), .out_val_2(ov[2]), .out_val_3(ov[3]),
      .out_val_4(ov[4]), .out_val_5(ov[5]), .out_val_6(ov[6]), .out_val_7(ov[7])
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: the payload is treated as a flat bit string, fields are
   // located by summing table widths.
   function automatic int model_total(input logic [15:0] bm);
      int wtab [4] = '{0, 8, 16, 32};
      int t = 0;
      for (int i = 0; i < 8; i++) t += wtab[bm[2*i +: 2]];
      return t;
   endfunction

   function automatic logic [OUT_W-1:0] model_field(input logic [15:0] bm,
                                                    input logic [31:0] w [8],
                                                    input int idx);
      int wtab [4] = '{0, 8, 16, 32};
      int pos = 0;
      int width;
      logic [63:0] v = 0;
      for (int i = 0; i < idx; i++) pos += wtab[bm[2*i +: 2]];
      width = wtab[bm[2*idx +: 2]];
      for (int j = 0; j < width; j++)
         if (w[(pos + j) / 32][(pos + j) % 32]) v += (64'd1 << j);
`ifdef UNPACK_SIGN_EXT_EN
      if (width > 0 && v[width-1]) v = v - (64'd1 << width);
`endif
      return v[OUT_W-1:0];
   endfunction

   task automatic push(input logic [31:0] word);
      int n = 0;
      @(negedge clk);
      in_data  = word;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Sends header + payload, then checks the emitted set against the model.
   task automatic load_block(input logic [31:0] hdr, input logic [31:0] w [8]);
      int tot = model_total(hdr[15:0]);
      int nw  = (tot + 31) / 32;
      push(hdr);
      for (int k = 0; k < nw; k++) push(w[k]);
      chk("out_valid_latency", out_valid, 1);
      chk("in_ready_emit", in_ready, 0);
      chk("out_bitmap", out_bitmap, hdr[15:0]);
      chk("out_total", out_total, tot);
      for (int i = 0; i < 8; i++)
         chk($sformatf("out_val_%0d", i), ov[i], model_field(hdr[15:0], w, i));
   endtask

   task automatic release_block();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("out_valid_after_ready", out_valid, 0);
      chk("in_ready_after_ready", in_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w [8];
      logic [OUT_W-1:0] held [8];
      logic [15:0] bm;

      rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
      foreach (w[k]) w[k] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_bitmap", out_bitmap, 0);
      chk("rst_out_total", out_total, 0);
      for (int i = 0; i < 8; i++) chk($sformatf("rst_val_%0d", i), ov[i], 0);
      @(negedge clk);
      rst = 1'b0;

      // Zero-length block
      load_block(32'h0000_0000, w);
      release_block();

      // Eight 8-bit fields
      w[0] = 32'h4433_2211; w[1] = 32'h8877_6655;
      load_block(32'h0000_5555, w);
      chk("t2_total", out_total, 64);
      chk("t2_val_0", ov[0], 32'h11);
      chk("t2_val_7", ov[7], 32'h88);
      release_block();

      // 16-bit then 8-bit field, top byte ignored
      foreach (w[k]) w[k] = '0;
      w[0] = 32'hDDCC_BBAA;
      load_block(32'h0000_0006, w);
      chk("t3_total", out_total, 24);
      chk("t3_val_0", ov[0], 32'hBBAA);
      chk("t3_val_1", ov[1], 32'hCC);
      chk("t3_val_2", ov[2], 32'h0);
      release_block();

      // Full 256-bit block, header high half ignored
      foreach (w[k]) w[k] = k;
      load_block(32'hABCD_FFFF, w);
      chk("t4_bitmap", out_bitmap, 16'hFFFF);
      chk("t4_total", out_total, 256);
      chk("t4_val_5", ov[5], 32'h5);
      release_block();

      // Backpressure: hold, with a new header offered during the hold
      w[0] = 32'h4433_2211; w[1] = 32'h8877_6655;
      load_block(32'h0000_5555, w);
      foreach (held[i]) held[i] = ov[i];
      @(negedge clk);
      in_data = 32'h0000_0000; in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         chk("t5_hold_valid", out_valid, 1);
         chk("t5_hold_in_ready", in_ready, 0);
         chk("t5_hold_total", out_total, 64);
         for (int i = 0; i < 8; i++) chk("t5_hold_val", ov[i], held[i]);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("t5_release_valid", out_valid, 0);
      chk("t5_release_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("t5_new_hdr_valid", out_valid, 1);
      chk("t5_new_hdr_total", out_total, 0);
      chk("t5_new_hdr_bitmap", out_bitmap, 0);
      release_block();

      // Reset in the middle of a block
      push(32'h0000_5555);
      push(32'h4433_2211);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t6_rst_valid", out_valid, 0);
      chk("t6_rst_in_ready", in_ready, 1);
      chk("t6_rst_bitmap", out_bitmap, 0);
      chk("t6_rst_total", out_total, 0);
      chk("t6_rst_val_0", ov[0], 0);
      @(negedge clk);
      rst = 1'b0;
      foreach (w[k]) w[k] = '0;
      load_block(32'h0000_0000, w);
      for (int i = 0; i < 8; i++) chk("t6_zero_val", ov[i], 0);
      release_block();

`ifdef UNPACK_SIGN_EXT_EN
      foreach (w[k]) w[k] = '0;
      w[0] = 32'h0000_0080;
      load_block(32'h0000_0001, w);
      chk("sext_val_0", ov[0], 32'hFFFF_FF80);
      release_block();
`endif

      // Random blocks against the model
      for (int b = 0; b < 25; b++) begin
         bm = 16'($urandom);
         foreach (w[k]) w[k] = $urandom;
         load_block({16'($urandom), bm}, w);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         chk("rnd_hold_valid", out_valid, 1);
         release_block();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
